// File: rtl/sc_level_progress_tracker_pkg.sv
// Shared definitions for the level progress tracker: state encoding and width helpers.
package sc_levelprogress_pkg;

  localparam int STATE_WIDTH = 3;

  typedef enum logic [STATE_WIDTH-1:0] {
    ST_IDLE       = 3'd0,
    ST_RUN        = 3'd1,
    ST_PAUSE      = 3'd2,
    ST_LEVEL_DONE = 3'd3,
    ST_GAME_WON   = 3'd4,
    ST_GAME_OVER  = 3'd5
  } state_t;

  // Ceiling log2; returns 0 for values of 1 or less.
  function automatic int clog2(input int value);
    int result;
    int span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span * 2;
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sc_level_progress_tracker_prescaler.sv
// Distance-tick prescaler: emits one step pulse per TICK_DIV enabled ticks.
module sc_tick_prescaler
  import sc_levelprogress_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  input  logic tick,
  output logic step
);

  localparam int CNT_WIDTH = (TICK_DIV > 1) ? clog2(TICK_DIV) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TICK_DIV - 1);

  logic [CNT_WIDTH-1:0] count_q;
  logic                 advance;

  assign advance = enable & tick;
  // With TICK_DIV=1 the count never leaves 0, so step reduces to tick & enable.
  assign step    = advance & (count_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= '0;
    end else if (step) begin
      count_q <= '0;
    end else if (advance) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/sc_level_progress_tracker.sv
// Multi-level progress tracker: counts prescaled distance ticks, sequences levels,
// reports win/game-over and drives a thermometer progress bar.
//
// state      | meaning
// IDLE       | waiting for first start after reset
// RUN        | counting progress steps within the current level
// PAUSE      | crash/pause, progress and prescaler frozen
// LEVEL_DONE | level complete, holding for DONE_HOLD cycles
// GAME_WON   | final level complete, waiting for restart
// GAME_OVER  | aborted, waiting for restart
module sc_level_progress_tracker
  import sc_levelprogress_pkg::*;
#(
  parameter int PROG_WIDTH   = 5,
  parameter int LEVEL_LENGTH = 31,
  parameter int NUM_LEVELS   = 4,
  parameter int LEVEL_WIDTH  = 2,
  parameter int TICK_DIV     = 1,
  parameter int DONE_HOLD    = 8,
  parameter int BAR_WIDTH    = 8
) (
  input  logic                   SC_LEVELTRACKER_CLOCK_50,
  input  logic                   SC_LEVELTRACKER_RESET_InHigh,
  input  logic                   SC_LEVELTRACKER_Start_in,
  input  logic                   SC_LEVELTRACKER_Tick_in,
  input  logic                   SC_LEVELTRACKER_Pause_in,
  input  logic                   SC_LEVELTRACKER_Abort_in,
  output logic [PROG_WIDTH-1:0]  SC_LEVELTRACKER_Progress_OutBus,
  output logic [LEVEL_WIDTH-1:0] SC_LEVELTRACKER_Level_OutBus,
  output logic [BAR_WIDTH-1:0]   SC_LEVELTRACKER_Bar_OutBus,
  output logic [STATE_WIDTH-1:0] SC_LEVELTRACKER_State_OutBus,
  output logic                   SC_LEVELTRACKER_LevelDone_out,
  output logic                   SC_LEVELTRACKER_GameWon_out,
  output logic                   SC_LEVELTRACKER_GameOver_out
);

  localparam int HOLD_WIDTH     = (DONE_HOLD > 1) ? clog2(DONE_HOLD) : 1;
  localparam int BAR_CALC_WIDTH = PROG_WIDTH + clog2(BAR_WIDTH) + 1;

  localparam logic [PROG_WIDTH-1:0]  PROG_FULL  = PROG_WIDTH'(LEVEL_LENGTH);
  localparam logic [PROG_WIDTH-1:0]  PROG_LAST  = PROG_WIDTH'(LEVEL_LENGTH - 1);
  localparam logic [LEVEL_WIDTH-1:0] LEVEL_LAST = LEVEL_WIDTH'(NUM_LEVELS - 1);
  localparam logic [HOLD_WIDTH-1:0]  HOLD_LAST  = HOLD_WIDTH'(DONE_HOLD - 1);

  logic clk;
  logic rst;
  logic start;
  logic tick;
  logic pause;
  logic abort;

  assign clk   = SC_LEVELTRACKER_CLOCK_50;
  assign rst   = SC_LEVELTRACKER_RESET_InHigh;
  assign start = SC_LEVELTRACKER_Start_in;
  assign tick  = SC_LEVELTRACKER_Tick_in;
  assign pause = SC_LEVELTRACKER_Pause_in;
  assign abort = SC_LEVELTRACKER_Abort_in;

  state_t                 state_q, state_d;
  logic [PROG_WIDTH-1:0]  progress_q, progress_d;
  logic [LEVEL_WIDTH-1:0] level_q, level_d;
  logic [HOLD_WIDTH-1:0]  hold_q, hold_d;
  logic                   level_done_q, level_done_d;

  logic pre_clear;
  logic pre_enable;
  logic step;

  // Abort and pause both outrank the tick, so the prescaler only sees clean RUN cycles.
  assign pre_enable = (state_q == ST_RUN) & ~abort & ~pause;

  sc_tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .clear  (pre_clear),
    .enable (pre_enable),
    .tick   (tick),
    .step   (step)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      progress_q   <= '0;
      level_q      <= '0;
      hold_q       <= '0;
      level_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      progress_q   <= progress_d;
      level_q      <= level_d;
      hold_q       <= hold_d;
      level_done_q <= level_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    progress_d   = progress_q;
    level_d      = level_q;
    hold_d       = hold_q;
    level_done_d = 1'b0;
    pre_clear    = 1'b0;

    case (state_q)
      ST_IDLE, ST_GAME_WON, ST_GAME_OVER: begin
        if (start) begin
          state_d    = ST_RUN;
          progress_d = '0;
          level_d    = '0;
          hold_d     = '0;
          pre_clear  = 1'b1;
        end
      end

      ST_RUN: begin
        if (abort) begin
          state_d = ST_GAME_OVER;
        end else if (pause) begin
          state_d = ST_PAUSE;
        end else if (step) begin
          if (progress_q == PROG_LAST) begin
            progress_d   = PROG_FULL;
            state_d      = ST_LEVEL_DONE;
            level_done_d = 1'b1;
            hold_d       = '0;
          end else begin
            progress_d = progress_q + 1'b1;
          end
        end
      end

      ST_PAUSE: begin
        if (abort) begin
          state_d = ST_GAME_OVER;
        end else if (!pause) begin
          state_d = ST_RUN;
        end
      end

      ST_LEVEL_DONE: begin
        if (abort) begin
          state_d = ST_GAME_OVER;
        end else if (hold_q == HOLD_LAST) begin
          if (level_q == LEVEL_LAST) begin
            state_d = ST_GAME_WON;
          end else begin
            state_d    = ST_RUN;
            level_d    = level_q + 1'b1;
            progress_d = '0;
            pre_clear  = 1'b1;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bar compares scaled progress against per-segment thresholds; widths sized to avoid overflow.
  logic [BAR_CALC_WIDTH-1:0] scaled_progress;

  assign scaled_progress = BAR_CALC_WIDTH'(progress_q) * BAR_CALC_WIDTH'(BAR_WIDTH);

  for (genvar i = 0; i < BAR_WIDTH; i++) begin : g_bar
    localparam logic [BAR_CALC_WIDTH-1:0] THRESHOLD = BAR_CALC_WIDTH'((i + 1) * LEVEL_LENGTH);
    assign SC_LEVELTRACKER_Bar_OutBus[i] = (scaled_progress >= THRESHOLD);
  end

  assign SC_LEVELTRACKER_Progress_OutBus = progress_q;
  assign SC_LEVELTRACKER_Level_OutBus    = level_q;
  assign SC_LEVELTRACKER_State_OutBus    = state_q;
  assign SC_LEVELTRACKER_LevelDone_out   = level_done_q;
  assign SC_LEVELTRACKER_GameWon_out     = (state_q == ST_GAME_WON);
  assign SC_LEVELTRACKER_GameOver_out    = (state_q == ST_GAME_OVER);

endmodule

// File: tb/tb_sc_level_progress_tracker.sv
// Bench for sc_level_progress_tracker: three parameterisations share one stimulus stream.
module tb_sc_level_progress_tracker;
  import sc_levelprogress_pkg::*;

  localparam int N = 3;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_LD = 3, S_WON = 4, S_OVER = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, tick, pause, abort;

  logic [4:0] prog_o [N];
  logic [1:0] lvl_o  [N];
  logic [7:0] bar_o  [N];
  logic [2:0] st_o   [N];
  logic       done_o [N];
  logic       won_o  [N];
  logic       over_o [N];

  int tests = 0;
  int fails = 0;

  // instance 0: defaults; 1: prescaled short levels; 2: two short levels
  int p_len [N] = '{31, 4, 3};
  int p_div [N] = '{1, 2, 1};
  int p_nlv [N] = '{4, 4, 2};
  int p_dh  [N] = '{8, 3, 2};

  int m_st [N], m_prog [N], m_lvl [N], m_pre [N], m_hold [N], m_done [N];

  sc_level_progress_tracker dut_a (
    .SC_LEVELTRACKER_CLOCK_50(clk), .SC_LEVELTRACKER_RESET_InHigh(rst),
    .SC_LEVELTRACKER_Start_in(start), .SC_LEVELTRACKER_Tick_in(tick),
    .SC_LEVELTRACKER_Pause_in(pause), .SC_LEVELTRACKER_Abort_in(abort),
    .SC_LEVELTRACKER_Progress_OutBus(prog_o[0]), .SC_LEVELTRACKER_Level_OutBus(lvl_o[0]),
    .SC_LEVELTRACKER_Bar_OutBus(bar_o[0]), .SC_LEVELTRACKER_State_OutBus(st_o[0]),
    .SC_LEVELTRACKER_LevelDone_out(done_o[0]), .SC_LEVELTRACKER_GameWon_out(won_o[0]),
    .SC_LEVELTRACKER_GameOver_out(over_o[0])
  );

  sc_level_progress_tracker #(.LEVEL_LENGTH(4), .TICK_DIV(2), .DONE_HOLD(3)) dut_b (
    .SC_LEVELTRACKER_CLOCK_50(clk), .SC_LEVELTRACKER_RESET_InHigh(rst),
    .SC_LEVELTRACKER_Start_in(start), .SC_LEVELTRACKER_Tick_in(tick),
    .SC_LEVELTRACKER_Pause_in(pause), .SC_LEVELTRACKER_Abort_in(abort),
    .SC_LEVELTRACKER_Progress_OutBus(prog_o[1]), .SC_LEVELTRACKER_Level_OutBus(lvl_o[1]),
    .SC_LEVELTRACKER_Bar_OutBus(bar_o[1]), .SC_LEVELTRACKER_State_OutBus(st_o[1]),
    .SC_LEVELTRACKER_LevelDone_out(done_o[1]), .SC_LEVELTRACKER_GameWon_out(won_o[1]),
    .SC_LEVELTRACKER_GameOver_out(over_o[1])
  );

  sc_level_progress_tracker #(.LEVEL_LENGTH(3), .NUM_LEVELS(2), .DONE_HOLD(2)) dut_c (
    .SC_LEVELTRACKER_CLOCK_50(clk), .SC_LEVELTRACKER_RESET_InHigh(rst),
    .SC_LEVELTRACKER_Start_in(start), .SC_LEVELTRACKER_Tick_in(tick),
    .SC_LEVELTRACKER_Pause_in(pause), .SC_LEVELTRACKER_Abort_in(abort),
    .SC_LEVELTRACKER_Progress_OutBus(prog_o[2]), .SC_LEVELTRACKER_Level_OutBus(lvl_o[2]),
    .SC_LEVELTRACKER_Bar_OutBus(bar_o[2]), .SC_LEVELTRACKER_State_OutBus(st_o[2]),
    .SC_LEVELTRACKER_LevelDone_out(done_o[2]), .SC_LEVELTRACKER_GameWon_out(won_o[2]),
    .SC_LEVELTRACKER_GameOver_out(over_o[2])
  );

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_all();
    rst = 1'b1; start = 1'b0; tick = 1'b0; pause = 1'b0; abort = 1'b0;
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic start_game();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  // Game rules applied to one instance for the edge just taken.
  task automatic model_step(input int k);
    if (rst) begin
      m_st[k] = S_IDLE; m_prog[k] = 0; m_lvl[k] = 0; m_pre[k] = 0; m_hold[k] = 0; m_done[k] = 0;
      return;
    end
    m_done[k] = 0;
    case (m_st[k])
      S_IDLE, S_WON, S_OVER: if (start) begin
        m_st[k] = S_RUN; m_prog[k] = 0; m_lvl[k] = 0; m_pre[k] = 0;
      end
      S_RUN: begin
        if (abort) m_st[k] = S_OVER;
        else if (pause) m_st[k] = S_PAUSE;
        else if (tick) begin
          m_pre[k]++;
          if (m_pre[k] == p_div[k]) begin
            m_pre[k] = 0;
            m_prog[k]++;
            if (m_prog[k] == p_len[k]) begin
              m_st[k] = S_LD; m_done[k] = 1; m_hold[k] = 0;
            end
          end
        end
      end
      S_PAUSE: begin
        if (abort) m_st[k] = S_OVER;
        else if (!pause) m_st[k] = S_RUN;
      end
      S_LD: begin
        if (abort) m_st[k] = S_OVER;
        else if (m_hold[k] == p_dh[k] - 1) begin
          if (m_lvl[k] == p_nlv[k] - 1) m_st[k] = S_WON;
          else begin
            m_lvl[k]++; m_prog[k] = 0; m_pre[k] = 0; m_st[k] = S_RUN;
          end
        end else m_hold[k]++;
      end
      default: m_st[k] = S_IDLE;
    endcase
  endtask

  task automatic test_reset();
    reset_all();
    for (int k = 0; k < N; k++) begin
      tests++;
      if ({st_o[k], prog_o[k], lvl_o[k], bar_o[k], done_o[k], won_o[k], over_o[k]} !== 21'd0) begin
        fails++;
        $display("FAIL reset_outputs dut%0d: state=%0d prog=%0d level=%0d bar=%h done=%b won=%b over=%b, required all 0",
                 k, st_o[k], prog_o[k], lvl_o[k], bar_o[k], done_o[k], won_o[k], over_o[k]);
      end
    end
  endtask

  task automatic test_level_complete();
    int pulses;
    reset_all();
    start_game();
    tick = 1'b1;
    cyc(30);
    tests++;
    if ({st_o[0], prog_o[0]} !== {3'd1, 5'd30}) begin
      fails++; $display("FAIL lvl_before_last dut0: state=%0d prog=%0d, required 1/30", st_o[0], prog_o[0]);
    end
    cyc(1);
    tests++;
    if ({st_o[0], prog_o[0], bar_o[0], done_o[0]} !== {3'd3, 5'd31, 8'hFF, 1'b1}) begin
      fails++;
      $display("FAIL lvl_complete dut0: state=%0d prog=%0d bar=%h done=%b, required 3/31/ff/1",
               st_o[0], prog_o[0], bar_o[0], done_o[0]);
    end
    // ticks keep arriving during the hold and must be ignored
    pulses = 0;
    for (int c = 1; c < 8; c++) begin
      cyc(1);
      if (done_o[0]) pulses++;
    end
    tests++;
    if ({st_o[0], prog_o[0], pulses[3:0]} !== {3'd3, 5'd31, 4'd0}) begin
      fails++;
      $display("FAIL lvl_hold dut0: state=%0d prog=%0d extra_pulses=%0d, required 3/31/0", st_o[0], prog_o[0], pulses);
    end
    cyc(1);
    tick = 1'b0;
    tests++;
    if ({st_o[0], prog_o[0], lvl_o[0]} !== {3'd1, 5'd0, 2'd1}) begin
      fails++;
      $display("FAIL lvl_next dut0: state=%0d prog=%0d level=%0d, required 1/0/1", st_o[0], prog_o[0], lvl_o[0]);
    end
  endtask

  task automatic test_prescaler();
    reset_all();
    start_game();
    for (int t = 1; t <= 8; t++) begin
      tick = 1'b1;
      cyc(1);
      tick = 1'b0;
      tests++;
      if (prog_o[1] !== 5'(t / 2)) begin
        fails++; $display("FAIL prescale_prog dut1 tick%0d: prog=%0d, required %0d", t, prog_o[1], t / 2);
      end
      if (t == 4) begin
        tests++;
        if (bar_o[1] !== 8'h0F) begin
          fails++; $display("FAIL prescale_bar dut1: bar=%h, required 0f", bar_o[1]);
        end
      end
      if (t == 8) begin
        tests++;
        if ({st_o[1], bar_o[1], done_o[1]} !== {3'd3, 8'hFF, 1'b1}) begin
          fails++;
          $display("FAIL prescale_done dut1: state=%0d bar=%h done=%b, required 3/ff/1", st_o[1], bar_o[1], done_o[1]);
        end
      end
      cyc(1);
    end
  endtask

  task automatic test_pause();
    reset_all();
    start_game();
    tick = 1'b1;
    cyc(10);
    pause = 1'b1;
    cyc(5);
    tests++;
    if ({st_o[0], prog_o[0]} !== {3'd2, 5'd10}) begin
      fails++; $display("FAIL pause_freeze dut0: state=%0d prog=%0d, required 2/10", st_o[0], prog_o[0]);
    end
    pause = 1'b0;
    tick = 1'b0;
    cyc(1);
    tests++;
    if ({st_o[0], prog_o[0]} !== {3'd1, 5'd10}) begin
      fails++; $display("FAIL pause_resume dut0: state=%0d prog=%0d, required 1/10", st_o[0], prog_o[0]);
    end
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    tests++;
    if (prog_o[0] !== 5'd11) begin
      fails++; $display("FAIL pause_tick dut0: prog=%0d, required 11", prog_o[0]);
    end
  endtask

  task automatic test_game_won();
    reset_all();
    start_game();
    tick = 1'b1;
    cyc(9);
    tests++;
    if ({st_o[2], lvl_o[2], prog_o[2]} !== {3'd3, 2'd1, 5'd3}) begin
      fails++;
      $display("FAIL won_last_level dut2: state=%0d level=%0d prog=%0d, required 3/1/3", st_o[2], lvl_o[2], prog_o[2]);
    end
    cyc(1);
    tests++;
    if ({st_o[2], won_o[2], lvl_o[2], prog_o[2], bar_o[2]} !== {3'd4, 1'b1, 2'd1, 5'd3, 8'hFF}) begin
      fails++;
      $display("FAIL won_enter dut2: state=%0d won=%b level=%0d prog=%0d bar=%h, required 4/1/1/3/ff",
               st_o[2], won_o[2], lvl_o[2], prog_o[2], bar_o[2]);
    end
    cyc(5);
    tests++;
    if ({st_o[2], lvl_o[2], prog_o[2]} !== {3'd4, 2'd1, 5'd3}) begin
      fails++;
      $display("FAIL won_frozen dut2: state=%0d level=%0d prog=%0d, required 4/1/3", st_o[2], lvl_o[2], prog_o[2]);
    end
    tick = 1'b0;
    start_game();
    tests++;
    if ({st_o[2], lvl_o[2], prog_o[2], won_o[2]} !== {3'd1, 2'd0, 5'd0, 1'b0}) begin
      fails++;
      $display("FAIL won_restart dut2: state=%0d level=%0d prog=%0d won=%b, required 1/0/0/0",
               st_o[2], lvl_o[2], prog_o[2], won_o[2]);
    end
  endtask

  task automatic test_abort();
    reset_all();
    start_game();
    tick = 1'b1;
    cyc(20);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    tick = 1'b0;
    tests++;
    if ({st_o[0], prog_o[0], over_o[0]} !== {3'd5, 5'd20, 1'b1}) begin
      fails++;
      $display("FAIL abort_run dut0: state=%0d prog=%0d over=%b, required 5/20/1", st_o[0], prog_o[0], over_o[0]);
    end
    start_game();
    tick = 1'b1;
    cyc(31);
    tick = 1'b0;
    cyc(2);
    abort = 1'b1;
    cyc(1);
    abort = 1'b0;
    tests++;
    if ({st_o[0], lvl_o[0], prog_o[0], over_o[0]} !== {3'd5, 2'd0, 5'd31, 1'b1}) begin
      fails++;
      $display("FAIL abort_level_done dut0: state=%0d level=%0d prog=%0d over=%b, required 5/0/31/1",
               st_o[0], lvl_o[0], prog_o[0], over_o[0]);
    end
  endtask

  task automatic test_reset_mid();
    reset_all();
    start_game();
    tick = 1'b1;
    cyc(30);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    tick = 1'b0;
    tests++;
    if ({st_o[0], prog_o[0], lvl_o[0], bar_o[0], done_o[0], won_o[0], over_o[0]} !== 21'd0) begin
      fails++;
      $display("FAIL reset_mid dut0: state=%0d prog=%0d level=%0d bar=%h done=%b, required all 0",
               st_o[0], prog_o[0], lvl_o[0], bar_o[0], done_o[0]);
    end
    cyc(1);
    tests++;
    if ({st_o[0], done_o[0]} !== {3'd0, 1'b0}) begin
      fails++; $display("FAIL reset_mid_pulse dut0: state=%0d done=%b, required 0/0", st_o[0], done_o[0]);
    end
    force dut_a.state_q = state_t'(3'd7);
    #1;
    tests++;
    if (st_o[0] !== 3'd7) begin
      fails++; $display("FAIL illegal_forced dut0: state=%0d, required 7", st_o[0]);
    end
    release dut_a.state_q;
    #1;
    cyc(1);
    tests++;
    if (st_o[0] !== 3'd0) begin
      fails++; $display("FAIL illegal_recover dut0: state=%0d, required 0", st_o[0]);
    end
  endtask

  task automatic test_random();
    rst = 1'b1; start = 1'b0; tick = 1'b0; pause = 1'b0; abort = 1'b0;
    @(posedge clk);
    for (int k = 0; k < N; k++) model_step(k);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst   = ($urandom_range(399) == 0);
      start = ($urandom_range(24) == 0);
      tick  = 1'($urandom_range(1));
      if ($urandom_range(15) == 0) pause = ~pause;
      abort = ($urandom_range(199) == 0);
      @(posedge clk);
      for (int k = 0; k < N; k++) model_step(k);
      #1;
      for (int k = 0; k < N; k++) begin
        int eb;
        logic [20:0] expv;
        eb = 0;
        for (int i = 0; i < 8; i++)
          if (m_prog[k] * 8 >= (i + 1) * p_len[k]) eb = eb | (1 << i);
        expv = {3'(m_st[k]), 5'(m_prog[k]), 2'(m_lvl[k]), 8'(eb), 1'(m_done[k]),
                m_st[k] == S_WON, m_st[k] == S_OVER};
        tests++;
        if ({st_o[k], prog_o[k], lvl_o[k], bar_o[k], done_o[k], won_o[k], over_o[k]} !== expv) begin
          fails++;
          $display("FAIL random dut%0d cyc%0d: state=%0d prog=%0d level=%0d bar=%h done=%b won=%b over=%b, required state=%0d prog=%0d level=%0d bar=%h done=%0d",
                   k, c, st_o[k], prog_o[k], lvl_o[k], bar_o[k], done_o[k], won_o[k], over_o[k],
                   m_st[k], m_prog[k], m_lvl[k], eb, m_done[k]);
        end
      end
    end
    rst = 1'b0; start = 1'b0; tick = 1'b0; pause = 1'b0; abort = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; tick = 1'b0; pause = 1'b0; abort = 1'b0;
    #2;
    test_reset();
    test_level_complete();
    test_prescaler();
    test_pause();
    test_game_won();
    test_abort();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sc_level_progress_tracker.md
Name: sc_level_progress_tracker

Overview:
- Parametrised, multi-level successor to the single-level progress counter in the RoadFighter design.
- Counts distance ticks from the game clock-divider/road-scroll logic, with a programmable prescaler.
- Tracks level index, signals level completion and holds for a programmable interval before the next level.
- Reports game-won / game-over, plus a thermometer progress bar for the LED/HUD driver.

Parameters:
PROG_WIDTH, 5, width of the progress counter
LEVEL_LENGTH, 31, progress steps per level; legal range 1 to 2^PROG_WIDTH-1
NUM_LEVELS, 4, number of levels per game; legal range 1 to 2^LEVEL_WIDTH
LEVEL_WIDTH, 2, width of the level index
TICK_DIV, 1, tick pulses per progress step; minimum 1
DONE_HOLD, 8, cycles spent in LEVEL_DONE; minimum 1
BAR_WIDTH, 8, thermometer bar segments

Ports:
SC_LEVELTRACKER_CLOCK_50  in  1  system clock, all logic on rising edge
SC_LEVELTRACKER_RESET_InHigh  in  1  synchronous, active-high reset
SC_LEVELTRACKER_Start_in  in  1  start/restart request, level-sensitive
SC_LEVELTRACKER_Tick_in  in  1  one-cycle distance tick
SC_LEVELTRACKER_Pause_in  in  1  crash/pause, freezes progress while high
SC_LEVELTRACKER_Abort_in  in  1  game over (fuel empty etc.)
SC_LEVELTRACKER_Progress_OutBus  out  PROG_WIDTH  progress within current level
SC_LEVELTRACKER_Level_OutBus  out  LEVEL_WIDTH  current level index, 0-based
SC_LEVELTRACKER_Bar_OutBus  out  BAR_WIDTH  thermometer progress bar
SC_LEVELTRACKER_State_OutBus  out  3  FSM state encoding
SC_LEVELTRACKER_LevelDone_out  out  1  one-cycle pulse on level completion
SC_LEVELTRACKER_GameWon_out  out  1  high while in GAME_WON
SC_LEVELTRACKER_GameOver_out  out  1  high while in GAME_OVER

Behaviour:
- Reset is synchronous and active-high, sampled on the clock edge, and overrides everything.
  - Reset values: state IDLE, progress 0, level 0, prescaler 0, hold counter 0.
  - Reset values of outputs: all outputs 0.
- State encoding: IDLE=0, RUN=1, PAUSE=2, LEVEL_DONE=3, GAME_WON=4, GAME_OVER=5. Codes 6-7 recover to IDLE next cycle.
- Input priority within a cycle: Abort > Pause > Tick. Start is honoured only in IDLE, GAME_WON and GAME_OVER.
- IDLE:
  - Start=1 -> RUN, with progress, level and prescaler cleared.
- RUN:
  - Abort=1 -> GAME_OVER.
  - Else Pause=1 -> PAUSE; the tick in that cycle is ignored and the prescaler is held.
  - Else, on Tick=1: prescaler increments. When the prescaler equals TICK_DIV-1, it clears and progress increments by 1.
  - When the increment makes progress equal LEVEL_LENGTH: progress registers LEVEL_LENGTH, state -> LEVEL_DONE, LevelDone pulses on that same edge for exactly 1 cycle, hold counter is cleared.
- PAUSE:
  - Ticks ignored; progress and prescaler frozen.
  - Abort=1 -> GAME_OVER. Pause=0 -> RUN on the next edge.
- LEVEL_DONE:
  - Progress holds at LEVEL_LENGTH; Tick and Pause are ignored; Abort=1 -> GAME_OVER.
  - Hold counter increments every cycle. When it reaches DONE_HOLD-1:
    - If level == NUM_LEVELS-1 -> GAME_WON, with level and progress held.
    - Else level+1, progress 0, prescaler 0 -> RUN.
- GAME_WON / GAME_OVER:
  - Progress, level and bar frozen; flag output high.
  - Start=1 -> RUN with all counters cleared, i.e. a restart without passing through IDLE.
- Progress never exceeds LEVEL_LENGTH and never wraps. Level never exceeds NUM_LEVELS-1.
- Bar is combinational from the registered progress:
  - Bar[i] = 1 iff progress*BAR_WIDTH >= (i+1)*LEVEL_LENGTH.
  - Intermediate width: PROG_WIDTH + clog2(BAR_WIDTH) + 1 bits, no truncation.
  - Full bar at LEVEL_LENGTH.
- Latency:
  - A tick affects progress on the next edge; all counter/state outputs are registered.
  - LevelDone is registered, asserted in the first cycle of LEVEL_DONE.
  - GameWon/GameOver are decoded from the state register.
- Reset mid-level returns to IDLE; a pending LevelDone pulse is suppressed.

Decomposition:
- Package sc_levelprogress_pkg:
  - State encoding constants (IDLE..GAME_OVER) and the 3-bit state width.
  - clog2 helper function used for the bar arithmetic width.
- Sub-module sc_tick_prescaler:
  - Parametrised by TICK_DIV; synchronous clear and enable.
  - Outputs a one-cycle step pulse.
  - With TICK_DIV=1 it degenerates to step = Tick & enable.

Test Plan:
1. Defaults; reset, Start 1 cycle, 31 ticks -> Progress 31, Bar 8'hFF, LevelDone high exactly 1 cycle, State 3; after 8 cycles Level 1, Progress 0, State 1.
2. TICK_DIV=2, LEVEL_LENGTH=4; 8 ticks on alternate cycles -> Progress steps on ticks 2/4/6/8, reaches 4; Bar after tick 4 (progress 2) = 8'h0F.
3. Pause high during 5 ticks mid-level at Progress 10 -> Progress stays 10, State 2; Pause low plus 1 tick -> 11.
4. NUM_LEVELS=2, LEVEL_LENGTH=3 -> complete both levels -> State 4, GameWon 1, Level 1; further ticks have no effect; Start -> State 1, Level 0, Progress 0.
5. Abort and Tick together at Progress 20 -> State 5, Progress 20, GameOver 1; Abort during LEVEL_DONE -> GAME_OVER, no level increment.
6. Reset asserted in RUN at Progress 30 with Tick high -> next cycle all outputs 0, no LevelDone pulse; illegal state code forced to 7 -> IDLE next cycle.
